multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle FSM controller for the 8-bit processor datapath. It sequences fetch/decode/exec/mem/writeback
//  over variable-latency instruction and data memories (req/ack handshake) and emits one-cycle datapath strobes.
//  Sits between the shared IR/PC/ALU/regfile datapath and the memory ports. It retires one instruction at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles FETCH/MEM waits for ack before error; counter width $clog2(TIMEOUT_CYCLES)+1
// PORTS
//  clk         in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high
//  run         in   1  1 = keep issuing instructions; sampled at instruction boundary
//  opcode      in   4  IR[opcode]; stable from cycle after ir_load until next ir_load
//  func        in   3  IR[func]; same stability as opcode
//  zero        in   1  ALU zero flag, valid in EXEC
//  imem_req    out  1  instruction fetch request, held until imem_ack
//  imem_ack    in   1  fetch data valid this cycle
//  dmem_req    out  1  data memory request, held until dmem_ack
//  dmem_ack    in   1  data access complete this cycle
//  ir_load     out  1  strobe: capture instruction
//  pc_en       out  1  strobe: PC write
//  pc_src      out  2  00 PC+1, 01 branch target, 10 jump target
//  alu_load    out  1  strobe: capture ALU result
//  mdr_load    out  1  strobe: capture load data
//  AluControl  out  3  ALU op; AluSrc out 1 imm operand; r2Chooser out 1 rd as 2nd read reg
//  MemWrite    out  1  level, with dmem_req on store; MemtoReg out 1 WB source select
//  RegWrite    out  1  strobe: register file write; jump out 1 / branch out 1 decode indicators
//  busy        out  1  1 in any state except IDLE/HALT; err out 1 sticky error, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, timeout counter 0. Reset mid-instruction aborts immediately.
//   No RegWrite/MemWrite strobe completes, and dmem_req/imem_req drop with reset.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
//  IDLE: run=1 -> FETCH.
//  FETCH: imem_req=1. On imem_ack: ir_load=1, pc_en=1, pc_src=00 -> DECODE.
//  DECODE (1 cycle):
//   - jump 0010: jump=1, pc_en=1, pc_src=10 -> boundary.
//   - legal ops -> EXEC; illegal op -> see CONFIGURATION.
//  EXEC (1 cycle): AluControl/AluSrc/r2Chooser per opcode.
//   - R-type 0000: AluControl=func, func 111 illegal.
//   - ADDI 0100 / LW 1011 / SW 1111: AluControl=000, AluSrc=1, r2Chooser=1 on SW only.
//   - BEQ 1000: AluControl=111, branch=1, pc_en=zero, pc_src=01 -> boundary.
//   - Others: alu_load=1; R/ADDI -> WB, LW/SW -> MEM.
//  MEM: dmem_req=1; MemWrite=1 for SW. On dmem_ack: LW: mdr_load=1 -> WB; SW -> boundary.
//  WB (1 cycle): RegWrite=1; MemtoReg=1 for LW -> boundary.
//  Boundary: run=1 -> FETCH, else IDLE. run is ignored mid-instruction.
//  Level controls hold stable DECODE..end of instruction; 0 in IDLE/FETCH/HALT.
//   Strobes are high exactly one cycle.
//  Latency, zero-wait acks, ack in first req cycle:
//   JMP 2, BEQ 3, R/ADDI/SW 4, LW 5 cycles.
//  Timeout: counter clears on entry to FETCH/MEM and increments each cycle without ack.
//   - Ack on the same cycle the count reaches TIMEOUT_CYCLES-1: ack wins, normal progress.
//   - Count hits TIMEOUT_CYCLES-1 with no ack: err=1 -> HALT, no strobes that cycle.
//  HALT: all outputs 0 except err; exit only by reset.
//  Acks outside the matching state are ignored.
// CONFIGURATION
//  TRAP_ILLEGAL_EN defined:
//   - Illegal op (undefined opcode, or 0000 with func 111) in DECODE: err=1 -> HALT.
//  TRAP_ILLEGAL_EN undefined:
//   - Illegal op retires as NOP: no strobes in DECODE -> boundary; err stays 0.
//   - PC has already advanced in FETCH.
// TESTING
//  - ADD (op 0000 func 010), acks immediate, run=1: DECODE->EXEC (AluControl=010, alu_load) -> WB (RegWrite 1 cycle).
//     Next FETCH at cycle 4.
//  - LW (1011), dmem_ack delayed 3 cycles: dmem_req held 4 cycles, then mdr_load; WB has MemtoReg=1, RegWrite=1.
//     5+3 cycles total.
//  - BEQ (1000), zero=1 then zero=0: pc_en=1 with pc_src=01 in EXEC; with zero=0, pc_en=0 in EXEC.
//     No RegWrite in either case.
//  - imem_ack never asserted, TIMEOUT_CYCLES=16: err=1 and HALT after 16 FETCH cycles.
//     Ack on cycle 16 instead: normal DECODE, err=0.
//  - Opcode 0110: with TRAP_ILLEGAL_EN, err=1 and HALT. Without it, NOP and FETCH next cycle.
//  - SW in MEM, reset pulsed before dmem_ack: dmem_req/MemWrite drop asynchronously, state IDLE, busy=0.
//     After release with run=1, FETCH restarts.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback controller for the 8-bit datapath, with req/ack memory timeouts.
// Optional build macro TRAP_ILLEGAL_EN: illegal opcodes halt with err instead of retiring as a NOP.
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic [2:0] func,
    input  logic       zero,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    input  logic       dmem_ack,
    output logic       ir_load,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_load,
    output logic       mdr_load,
    output logic [2:0] AluControl,
    output logic       AluSrc,
    output logic       r2Chooser,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       jump,
    output logic       branch,
    output logic       busy,
    output logic       err
);

    localparam int              CW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_JMP   = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_SW    = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic w_is_r, w_is_jmp, w_is_addi, w_is_beq, w_is_lw, w_is_sw;
    logic w_legal, w_in_instr;

    assign w_is_r     = (opcode == OP_RTYPE) && (func != 3'b111);
    assign w_is_jmp   = (opcode == OP_JMP);
    assign w_is_addi  = (opcode == OP_ADDI);
    assign w_is_beq   = (opcode == OP_BEQ);
    assign w_is_lw    = (opcode == OP_LW);
    assign w_is_sw    = (opcode == OP_SW);
    assign w_legal    = w_is_r | w_is_jmp | w_is_addi | w_is_beq | w_is_lw | w_is_sw;
    assign w_in_instr = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                        (r_state == S_MEM)    || (r_state == S_WB);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_count <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state <= S_DECODE;
                    end else if (r_count == LIMIT) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_is_jmp) begin
                        r_state <= run ? S_FETCH : S_IDLE;
                        r_count <= '0;
                    end else if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
`ifdef TRAP_ILLEGAL_EN
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
`else
                        r_state <= run ? S_FETCH : S_IDLE;
                        r_count <= '0;
`endif
                    end
                end
                S_EXEC: begin
                    if (w_is_beq) begin
                        r_state <= run ? S_FETCH : S_IDLE;
                        r_count <= '0;
                    end else if (w_is_lw || w_is_sw) begin
                        r_state <= S_MEM;
                        r_count <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_state <= w_is_lw ? S_WB : (run ? S_FETCH : S_IDLE);
                        r_count <= '0;
                    end else if (r_count == LIMIT) begin
                        r_err   <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_WB: begin
                    r_state <= run ? S_FETCH : S_IDLE;
                    r_count <= '0;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from the state register plus the live ack/IR inputs: the IR is only valid from DECODE
    // onward and ir_load must coincide with imem_ack, so registering them would cost a cycle per step.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        busy       = (r_state != S_IDLE) && (r_state != S_HALT);
        err        = r_err;
        imem_req   = (r_state == S_FETCH);
        dmem_req   = (r_state == S_MEM);
        ir_load    = (r_state == S_FETCH) && imem_ack;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_load   = (r_state == S_EXEC) && !w_is_beq;
        mdr_load   = (r_state == S_MEM) && dmem_ack && w_is_lw;
        RegWrite   = (r_state == S_WB);
        MemWrite   = (r_state == S_MEM) && w_is_sw;
        MemtoReg   = w_in_instr && w_is_lw;
        AluSrc     = w_in_instr && (w_is_addi || w_is_lw || w_is_sw);
        r2Chooser  = w_in_instr && w_is_sw;
        jump       = w_in_instr && w_is_jmp;
        branch     = w_in_instr && w_is_beq;
        AluControl = 3'b000;
        if (w_in_instr) begin
            if (w_is_r)        AluControl = func;
            else if (w_is_beq) AluControl = 3'b111;
        end
        if (r_state == S_FETCH && imem_ack) begin
            pc_en = 1'b1;
        end else if (r_state == S_DECODE && w_is_jmp) begin
            pc_en  = 1'b1;
            pc_src = 2'b10;
        end else if (r_state == S_EXEC && w_is_beq) begin
            pc_en  = zero;
            pc_src = 2'b01;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table plus hand sequences for
// timeouts, illegal opcodes (behaviour follows TRAP_ILLEGAL_EN) and reset during a store.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic [2:0] func;
    logic       zero;
    logic       imem_req, imem_ack, dmem_req, dmem_ack;
    logic       ir_load, pc_en, alu_load, mdr_load;
    logic [1:0] pc_src;
    logic [2:0] AluControl;
    logic       AluSrc, r2Chooser, MemWrite, MemtoReg, RegWrite, jump, branch, busy, err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .func(func), .zero(zero),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src), .alu_load(alu_load), .mdr_load(mdr_load),
        .AluControl(AluControl), .AluSrc(AluSrc), .r2Chooser(r2Chooser), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .jump(jump), .branch(branch), .busy(busy), .err(err)
    );

    // ctl = {busy, err, imem_req, dmem_req}; stb = {ir_load, pc_en, alu_load, mdr_load, RegWrite};
    // lvl = {AluSrc, r2Chooser, MemWrite, MemtoReg, jump, branch}
    typedef struct {
        string      name;
        logic       run;
        logic [3:0] op;
        logic [2:0] fn;
        logic       z, ia, da;
        logic [3:0] ctl;
        logic [4:0] stb;
        logic [1:0] pcs;
        logic [2:0] aluc;
        logic [5:0] lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic [3:0] op, input logic [2:0] fn,
                       input logic z, input logic ia, input logic da, input logic [3:0] ctl,
                       input logic [4:0] stb, input logic [1:0] pcs, input logic [2:0] aluc,
                       input logic [5:0] lvl);
        vec_t v;
        v.name = name; v.run = r; v.op = op; v.fn = fn; v.z = z; v.ia = ia; v.da = da;
        v.ctl = ctl; v.stb = stb; v.pcs = pcs; v.aluc = aluc; v.lvl = lvl;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] op, input logic [2:0] fn,
                         input logic z, input logic ia, input logic da);
        run = r; opcode = op; func = fn; zero = z; imem_ack = ia; dmem_ack = da;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ctl, input logic [4:0] stb,
                         input logic [1:0] pcs, input logic [2:0] aluc, input logic [5:0] lvl);
        logic [19:0] act, expv;
        act  = {busy, err, imem_req, dmem_req, ir_load, pc_en, alu_load, mdr_load, RegWrite,
                pc_src, AluControl, AluSrc, r2Chooser, MemWrite, MemtoReg, jump, branch};
        expv = {ctl, stb, pcs, aluc, lvl};
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (ctl|stb|pc_src|aluc|lvl)", name, act, expv);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        drive(1'b0, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic illegal_op(input string name, input logic [3:0] op, input logic [2:0] fn);
        drive(1'b1, op, fn, 1'b0, 1'b0, 1'b0);
        #3; check({name, "_idle"}, 4'b0000, 5'b0, 2'b00, 3'b000, 6'b0);
        tick();
        imem_ack = 1'b1;
        #3; check({name, "_fetch"}, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b0);
        tick();
        imem_ack = 1'b0;
        #3; check({name, "_decode"}, 4'b1000, 5'b0, 2'b00, 3'b000, 6'b0);
        tick();
`ifdef TRAP_ILLEGAL_EN
        #3; check({name, "_halt"}, 4'b0100, 5'b0, 2'b00, 3'b000, 6'b0);
`else
        #3; check({name, "_refetch"}, 4'b1010, 5'b0, 2'b00, 3'b000, 6'b0);
`endif
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'h0, 3'h0, 1'b0, 1'b0, 1'b0);
        #2; check("reset_t0", 4'b0000, 5'b0, 2'b00, 3'b000, 6'b0);
        tick();
        run = 1'b1;
        #3; check("reset_held_run1", 4'b0000, 5'b0, 2'b00, 3'b000, 6'b0);
        tick();
        reset = 1'b0;

        add("idle_run0",  0, 4'b0000, 3'b000, 0, 0, 0, 4'b0000, 5'b00000, 2'b00, 3'b000, 6'b000000);
        add("idle_go",    1, 4'b0000, 3'b010, 0, 0, 0, 4'b0000, 5'b00000, 2'b00, 3'b000, 6'b000000);
        add("add_fetch",  1, 4'b0000, 3'b010, 0, 1, 0, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("add_dec",    1, 4'b0000, 3'b010, 0, 0, 0, 4'b1000, 5'b00000, 2'b00, 3'b010, 6'b000000);
        add("add_exec",   1, 4'b0000, 3'b010, 0, 0, 0, 4'b1000, 5'b00100, 2'b00, 3'b010, 6'b000000);
        add("add_wb",     1, 4'b0000, 3'b010, 0, 0, 0, 4'b1000, 5'b00001, 2'b00, 3'b010, 6'b000000);
        add("addi_wait",  1, 4'b0100, 3'b000, 0, 0, 0, 4'b1010, 5'b00000, 2'b00, 3'b000, 6'b000000);
        add("addi_fetch", 1, 4'b0100, 3'b000, 0, 1, 0, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("addi_dec",   1, 4'b0100, 3'b000, 0, 0, 0, 4'b1000, 5'b00000, 2'b00, 3'b000, 6'b100000);
        add("addi_exec",  1, 4'b0100, 3'b000, 0, 0, 0, 4'b1000, 5'b00100, 2'b00, 3'b000, 6'b100000);
        add("addi_wb",    1, 4'b0100, 3'b000, 0, 0, 0, 4'b1000, 5'b00001, 2'b00, 3'b000, 6'b100000);
        add("lw_fetch",   1, 4'b1011, 3'b000, 0, 1, 1, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("lw_dec",     1, 4'b1011, 3'b000, 0, 0, 0, 4'b1000, 5'b00000, 2'b00, 3'b000, 6'b100100);
        add("lw_exec",    1, 4'b1011, 3'b000, 0, 0, 0, 4'b1000, 5'b00100, 2'b00, 3'b000, 6'b100100);
        add("lw_mem_w1",  1, 4'b1011, 3'b000, 0, 0, 0, 4'b1001, 5'b00000, 2'b00, 3'b000, 6'b100100);
        add("lw_mem_w2",  1, 4'b1011, 3'b000, 0, 1, 0, 4'b1001, 5'b00000, 2'b00, 3'b000, 6'b100100);
        add("lw_mem_w3",  1, 4'b1011, 3'b000, 0, 0, 0, 4'b1001, 5'b00000, 2'b00, 3'b000, 6'b100100);
        add("lw_mem_ack", 1, 4'b1011, 3'b000, 0, 0, 1, 4'b1001, 5'b00010, 2'b00, 3'b000, 6'b100100);
        add("lw_wb",      1, 4'b1011, 3'b000, 0, 0, 0, 4'b1000, 5'b00001, 2'b00, 3'b000, 6'b100100);
        add("sw_fetch",   1, 4'b1111, 3'b000, 0, 1, 0, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("sw_dec",     1, 4'b1111, 3'b000, 0, 1, 1, 4'b1000, 5'b00000, 2'b00, 3'b000, 6'b110000);
        add("sw_exec",    1, 4'b1111, 3'b000, 0, 0, 0, 4'b1000, 5'b00100, 2'b00, 3'b000, 6'b110000);
        add("sw_mem_ack", 1, 4'b1111, 3'b000, 0, 0, 1, 4'b1001, 5'b00000, 2'b00, 3'b000, 6'b111000);
        add("beq1_fetch", 1, 4'b1000, 3'b000, 1, 1, 0, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("beq1_dec",   1, 4'b1000, 3'b000, 1, 0, 0, 4'b1000, 5'b00000, 2'b00, 3'b111, 6'b000001);
        add("beq1_exec",  1, 4'b1000, 3'b000, 1, 0, 0, 4'b1000, 5'b01000, 2'b01, 3'b111, 6'b000001);
        add("beq0_fetch", 1, 4'b1000, 3'b000, 0, 1, 0, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("beq0_dec",   1, 4'b1000, 3'b000, 0, 0, 0, 4'b1000, 5'b00000, 2'b00, 3'b111, 6'b000001);
        add("beq0_exec",  1, 4'b1000, 3'b000, 0, 0, 0, 4'b1000, 5'b00000, 2'b01, 3'b111, 6'b000001);
        add("jmp_fetch",  1, 4'b0010, 3'b000, 0, 1, 0, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("jmp_dec",    1, 4'b0010, 3'b000, 0, 0, 0, 4'b1000, 5'b01000, 2'b10, 3'b000, 6'b000010);
        add("r_fetch",    1, 4'b0000, 3'b110, 0, 1, 0, 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b000000);
        add("r_dec_run0", 0, 4'b0000, 3'b110, 0, 0, 0, 4'b1000, 5'b00000, 2'b00, 3'b110, 6'b000000);
        add("r_exec",     0, 4'b0000, 3'b110, 0, 0, 0, 4'b1000, 5'b00100, 2'b00, 3'b110, 6'b000000);
        add("r_wb",       0, 4'b0000, 3'b110, 0, 0, 0, 4'b1000, 5'b00001, 2'b00, 3'b110, 6'b000000);
        add("idle_after", 0, 4'b0000, 3'b000, 0, 0, 0, 4'b0000, 5'b00000, 2'b00, 3'b000, 6'b000000);
        add("idle_acks",  0, 4'b0000, 3'b000, 0, 1, 1, 4'b0000, 5'b00000, 2'b00, 3'b000, 6'b000000);

        foreach (vecs[i]) begin
            drive(vecs[i].run, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].ia, vecs[i].da);
            #3;
            check(vecs[i].name, vecs[i].ctl, vecs[i].stb, vecs[i].pcs, vecs[i].aluc, vecs[i].lvl);
            tick();
        end

        // Fetch never acknowledged: 16 FETCH cycles, then HALT with err that survives run and acks.
        do_reset();
        drive(1'b1, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 16; k++) begin
            #3; check($sformatf("to_fetch_%0d", k), 4'b1010, 5'b0, 2'b00, 3'b000, 6'b0);
            tick();
        end
        #3; check("to_halt", 4'b0100, 5'b0, 2'b00, 3'b000, 6'b0);
        tick();
        drive(1'b1, 4'b0000, 3'b010, 1'b0, 1'b1, 1'b1);
        #3; check("to_halt_stays", 4'b0100, 5'b0, 2'b00, 3'b000, 6'b0);

        // Ack arrives on the 16th fetch cycle: it wins over the timeout.
        do_reset();
        drive(1'b1, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k < 16; k++) tick();
        imem_ack = 1'b1;
        #3; check("ack16_fetch", 4'b1010, 5'b11000, 2'b00, 3'b000, 6'b0);
        tick();
        imem_ack = 1'b0;
        #3; check("ack16_decode", 4'b1000, 5'b0, 2'b00, 3'b010, 6'b0);
        do_reset();

        illegal_op("ill_0110", 4'b0110, 3'b000);
        illegal_op("ill_r111", 4'b0000, 3'b111);

        // Reset pulsed mid-store: requests drop without waiting for a clock edge.
        drive(1'b1, 4'b1111, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        #3; check("rst_sw_mem", 4'b1001, 5'b0, 2'b00, 3'b000, 6'b111000);
        #1 reset = 1'b1;
        #1; check("rst_async_drop", 4'b0000, 5'b0, 2'b00, 3'b000, 6'b0);
        tick();
        reset = 1'b0;
        #3; check("rst_idle", 4'b0000, 5'b0, 2'b00, 3'b000, 6'b0);
        tick();
        #3; check("rst_refetch", 4'b1010, 5'b0, 2'b00, 3'b000, 6'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
